// File: rtl/router_mode_ctrl_if.sv
// Handshake bundle between the four request sources and the router mode sequencer.
// Signal names match the original flat ports so existing connections map one-to-one.
interface router_mode_ctrl_if;
    logic [3:0] req_i;
    logic       bcast_i;
    logic       xfer_i;
    logic [3:0] grant_o;
    logic [2:0] router_mode_o;
    logic       busy_o;

    modport master (
        output req_i, bcast_i, xfer_i,
        input  grant_o, router_mode_o, busy_o
    );

    modport slave (
        input  req_i, bcast_i, xfer_i,
        output grant_o, router_mode_o, busy_o
    );
endinterface

// File: rtl/router_mode_ctrl.sv
// Round-robin arbiter and mode sequencer for the four-port mesh router.
// Each grant is held for a bounded burst and followed by a one-cycle drain gap.
module router_mode_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned CNT_W      = $clog2(BURST_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    router_mode_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SWITCH} state_t;
    typedef enum logic [2:0] {
        M_ALL = 3'd0, M_NORTH = 3'd1, M_SOUTH = 3'd2,
        M_WEST = 3'd3, M_EAST = 3'd4, M_NONE = 3'd7
    } mode_t;

    if (BURST_LEN < 1 || BURST_LEN > 255 || DATA_WIDTH == 0) begin : g_bad_param
        $error("router_mode_ctrl: BURST_LEN must be 1..255 and DATA_WIDTH nonzero");
    end

    state_t           r_state, w_state_nxt;
    mode_t            r_mode, w_mode_nxt;
    logic [3:0]       r_grant, w_grant_nxt;
    logic             r_busy, w_busy_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]       r_rr_ptr, w_ptr_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [1:0]       w_cand, w_win;
    logic             w_found;

    function automatic mode_t mode_of(input logic [1:0] idx, input logic bcast);
        case (idx)
            2'd0:    mode_of = M_NORTH;
            2'd1:    mode_of = M_SOUTH;
            2'd2:    mode_of = M_WEST;
            default: mode_of = bcast ? M_ALL : M_EAST;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mode   <= M_NONE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_grant  <= w_grant_nxt;
            r_busy   <= w_busy_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_ptr_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_grant_nxt = r_grant;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_rr_ptr;
        w_idx_nxt   = r_idx;
        w_cnt_inc   = r_cnt;
        w_cand      = '0;
        w_win       = '0;
        w_found     = 1'b0;

        // First requester at or above the pointer, wrapping modulo 4
        for (int unsigned i = 0; i < 4; i++) begin
            w_cand = r_rr_ptr + 2'(i);
            if (!w_found && bus.req_i[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end

        case (r_state)
            S_IDLE: begin
                w_mode_nxt  = M_NONE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_mode_nxt  = mode_of(w_win, bus.bcast_i);
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = w_win;
                end
            end
            S_GRANT: begin
                if (bus.xfer_i && r_cnt != CNT_W'(BURST_LEN))
                    w_cnt_inc = r_cnt + CNT_W'(1);
                w_cnt_nxt = w_cnt_inc;
                // Burst end and request drop share one exit, so the pointer advances once
                if (w_cnt_inc == CNT_W'(BURST_LEN) || !bus.req_i[r_idx]) begin
                    w_state_nxt = S_SWITCH;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = r_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_mode_nxt  = M_NONE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.grant_o       = r_grant;
    assign bus.router_mode_o = r_mode;
    assign bus.busy_o        = r_busy;

endmodule

// File: tb/tb_router_mode_ctrl.sv
// Directed bench for router_mode_ctrl: reset, rotation, early release, broadcast,
// simultaneous burst end and asynchronous reset during a burst.
module tb_router_mode_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    router_mode_ctrl_if bus();

    router_mode_ctrl #(.DATA_WIDTH(16), .BURST_LEN(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [2:0] m, input logic b);
        chk({tag, ".grant"}, 32'(bus.grant_o), 32'(g));
        chk({tag, ".mode"},  32'(bus.router_mode_o), 32'(m));
        chk({tag, ".busy"},  32'(bus.busy_o), 32'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] g;
        n_cmp = 0;
        n_err = 0;

        // Reset held with all sources requesting
        rst_n       = 1'b0;
        bus.req_i   = 4'b1111;
        bus.bcast_i = 1'b0;
        bus.xfer_i  = 1'b0;
        tick();
        tick();
        chk_out("reset", 4'b0000, 3'd7, 1'b0);
        chk("reset.cnt", 32'(dut.r_cnt), 32'd0);

        // Release, then rotation with continuous transfers
        rst_n      = 1'b1;
        bus.xfer_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            tick();
            chk_out($sformatf("rr%0d.grant", k), g, 3'((k % 4) + 1), 1'b1);
            if (k == 4) break;
            for (int c = 1; c < 8; c++) begin
                tick();
                chk($sformatf("rr%0d.hold%0d", k, c), 32'(bus.grant_o), 32'(g));
            end
            tick();
            chk_out($sformatf("rr%0d.switch", k), 4'b0000, 3'((k % 4) + 1), 1'b1);
            tick();
            chk_out($sformatf("rr%0d.idle", k), 4'b0000, 3'd7, 1'b1 ^ 1'b1);
        end

        // North granted again; advance to count 5 then reset asynchronously
        for (int c = 1; c <= 5; c++) tick();
        chk("arst.cnt5", 32'(dut.r_cnt), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst.async", 4'b0000, 3'd7, 1'b0);
        bus.req_i  = 4'b0000;
        bus.xfer_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst.cnt0", 32'(dut.r_cnt), 32'd0);
        chk("arst.ptr0", 32'(dut.r_rr_ptr), 32'd0);

        // Early release by west after 3 transfers
        bus.req_i = 4'b0100;
        tick();
        chk_out("early.grant", 4'b0100, 3'd3, 1'b1);
        bus.xfer_i = 1'b1;
        for (int c = 1; c <= 3; c++) tick();
        chk("early.cnt3", 32'(dut.r_cnt), 32'd3);
        bus.req_i  = 4'b0000;
        bus.xfer_i = 1'b0;
        tick();
        chk_out("early.switch", 4'b0000, 3'd3, 1'b1);
        bus.req_i = 4'b0011;
        tick();
        chk_out("early.idle", 4'b0000, 3'd7, 1'b0);
        tick();
        chk_out("early.wrap_north", 4'b0001, 3'd1, 1'b1);
        bus.req_i = 4'b0000;
        tick();
        tick();
        chk_out("early.idle2", 4'b0000, 3'd7, 1'b0);

        // Broadcast latched at grant, ignored afterwards
        bus.req_i   = 4'b1000;
        bus.bcast_i = 1'b1;
        tick();
        chk_out("bc.grant", 4'b1000, 3'd0, 1'b1);
        bus.xfer_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.bcast_i = ~bus.bcast_i;
            tick();
            chk($sformatf("bc.hold%0d", c), 32'(bus.router_mode_o), 32'd0);
        end
        bus.req_i  = 4'b0000;
        bus.xfer_i = 1'b0;
        tick();
        chk_out("bc.switch", 4'b0000, 3'd0, 1'b1);
        bus.req_i   = 4'b1000;
        bus.bcast_i = 1'b0;
        tick();
        chk_out("bc.idle", 4'b0000, 3'd7, 1'b0);
        tick();
        chk_out("bc.east", 4'b1000, 3'd4, 1'b1);
        bus.req_i = 4'b0000;
        tick();
        chk_out("bc.east_switch", 4'b0000, 3'd4, 1'b1);
        tick();

        // South: last burst word coincides with request drop
        bus.req_i = 4'b0010;
        tick();
        chk_out("sim.grant", 4'b0010, 3'd2, 1'b1);
        bus.xfer_i = 1'b1;
        for (int c = 1; c < 8; c++) tick();
        chk_out("sim.hold7", 4'b0010, 3'd2, 1'b1);
        bus.req_i = 4'b0000;
        tick();
        chk_out("sim.switch", 4'b0000, 3'd2, 1'b1);
        bus.xfer_i = 1'b0;
        bus.req_i  = 4'b1111;
        tick();
        chk_out("sim.idle", 4'b0000, 3'd7, 1'b0);
        chk("sim.ptr", 32'(dut.r_rr_ptr), 32'd2);
        tick();
        chk_out("sim.next_west", 4'b0100, 3'd3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
